// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default sizing for the
// scheduled sequence detector.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_WORD_W  = 8;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CNT_W   = 4;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial pattern matcher with overlap control and a
// saturating match counter.
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               bit_in,
    input  logic               bit_en,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               match,
    output logic [CNT_W-1:0]   count
);
    localparam int F_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] r_hist;
    logic [PAT_LEN-1:0] w_hist;
    logic [F_W-1:0]     r_fill;
    logic [F_W-1:0]     w_fill;
    logic               w_drop;

    // the decision looks at history including the bit arriving this cycle
    assign w_hist = {r_hist[PAT_LEN-2:0], bit_in};
    assign w_fill = (r_fill == F_W'(PAT_LEN)) ? r_fill : r_fill + 1'b1;
    assign match  = bit_en && (w_fill == F_W'(PAT_LEN)) && (w_hist == pattern);
    assign w_drop = match && !overlap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            count  <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
            count  <= '0;
        end else if (bit_en) begin
            r_hist <= w_drop ? '0 : w_hist;
            r_fill <= w_drop ? '0 : w_fill;
            count  <= (match && count != '1) ? count + 1'b1 : count;
        end
    end
endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin scheduler that streams each granted word
// MSB first through a shared matcher and returns its match count.
module seq_detect_sched
    import seq_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic [PAT_LEN-1:0]       cfg_pattern,
    input  logic                     cfg_overlap,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [CNT_W-1:0]         rsp_count,
    output logic                     busy
);
    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = $clog2(WORD_W);

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_sel;
    logic [ID_W-1:0]    w_idx;
    logic [WORD_W-1:0]  r_data;
    logic [PAT_LEN-1:0] r_pat;
    logic               r_ovl;
    logic [BC_W-1:0]    r_bitcnt;
    logic               w_grant;
    logic               w_last;
    logic               w_unused_match;

    // scan from the highest offset down so the nearest requester after r_ptr wins
    always_comb begin
        w_sel = r_ptr;
        w_idx = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_idx]) w_sel = w_idx;
        end
    end

    assign w_grant = (r_state == IDLE) && (|req_valid);
    assign w_last  = r_bitcnt == BC_W'(WORD_W - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            IDLE: if (w_grant) begin
                req_ready[w_sel] = !reset;
                w_next           = SHIFT;
            end
            SHIFT:   w_next = w_last ? RESP : SHIFT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_pat    <= '0;
            r_ovl    <= 1'b0;
            r_bitcnt <= '0;
        end else if (w_grant) begin
            r_ptr    <= (w_sel == ID_W'(NREQ - 1)) ? '0 : w_sel + 1'b1;
            r_id     <= w_sel;
            r_data   <= req_data[w_sel*WORD_W +: WORD_W];
            r_pat    <= cfg_pattern;
            r_ovl    <= cfg_overlap;
            r_bitcnt <= '0;
        end else if (r_state == SHIFT) begin
            r_data   <= r_data << 1;
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    seq_match_core #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_grant),
        .bit_in  (r_data[WORD_W-1]),
        .bit_en  (r_state == SHIFT),
        .pattern (r_pat),
        .overlap (r_ovl),
        .match   (w_unused_match),
        .count   (rsp_count)
    );

    assign rsp_valid = r_state == RESP;
    assign rsp_id    = r_id;
    assign busy      = r_state != IDLE;
endmodule
